lsu_dm_ctrl: RTL and testbench
==============================

Name: lsu_dm_ctrl

Overview:
- Load/store controller sitting between the EX/MEM pipeline register and the 64-word x 32-bit data memory.
- Accepts byte, halfword and word requests and converts them into word accesses on the memory.
- Partial stores are done as read-modify-write; loads are sign- or zero-extended.
- Holds the pipeline off with a ready/valid handshake while busy.

Parameters:
- AW, 6, word-address width on the memory side (64 words); byte address bits [AW+1:2] select the word.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address; bits above AW+1 ignored.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; misaligned access.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- dm_addr  out  AW  memory word address.
- dm_rd  out  1  memory returns write data this cycle; driven equal to dm_wr.
- dm_wr  out  1  memory write strobe.
- dm_wdata  out  32  memory write data.
- dm_rdata  in  32  memory read data, combinational.

Behaviour:
- Reset: state=IDLE. req_ready=1; resp_valid, resp_err, dm_wr, dm_rd = 0; resp_rdata, dm_addr, dm_wdata = 0.
- Captured registers: on acceptance, latch we/size/unsigned/addr/wdata; dm_addr = captured addr[AW+1:2].
- dm_wr/dm_rd are decoded from the state register only; no combinational path from req_* to dm_*.
- Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- States:
  - IDLE: req_ready=1. On accept: misaligned -> RESP with err; load -> LOAD; word store -> WR; byte/half store -> RMW_RD.
  - LOAD: dm_wr=0. dm_rdata lane extracted, then sign- or zero-extended to 32 bits and registered into resp_rdata -> RESP.
  - RMW_RD: dm_wr=0. Merge the captured byte/half into dm_rdata at its lane; register the result as dm_wdata -> RMW_WR.
  - WR / RMW_WR: dm_wr=dm_rd=1 for exactly one cycle with dm_wdata stable -> RESP. For WR, dm_wdata = captured wdata.
  - RESP: resp_valid=1 for one cycle, req_ready=0 -> IDLE.
- req_ready=0 in every state except IDLE.
- Latency (accept edge to resp_valid cycle): misaligned 1, load 2, word store 2, partial store 3.
- resp_rdata and resp_err hold their value until the next RESP.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. No memory access is made (dm_wr never asserted), resp_err=1, resp_rdata=0.
- Stores return resp_rdata=0 and resp_err=0.
- Address wrap: word index uses only addr[AW+1:2], so 0x100 aliases 0x000.
- Reset mid-operation: the state is abandoned immediately and dm_wr drops asynchronously. A partial store reset before RMW_WR leaves memory unchanged; no response is issued.
- req_valid while busy: the request is ignored and must be held by the upstream until req_ready.

Optional Feature:
- Macro LSU_ALIGN_CHK_EN.
- Defined: misalignment detection and error responses as above.
- Undefined:
  - No detection; resp_err is tied to 0.
  - Halfword uses addr[1] only and word ignores addr[1:0], so accesses are forced aligned and never error.

Test Plan:
- sw 0x04 data 0x8899AABB, then lw 0x04 -> dm_wr high exactly 1 cycle; resp_valid 2 cycles after each accept; resp_rdata=0x8899AABB, resp_err=0.
- With word 1=0x8899AABB:
  - lb 0x07 -> 0xFFFFFF88; lbu 0x07 -> 0x00000088.
  - lh 0x04 -> 0xFFFFAABB; lhu 0x06 -> 0x00008899.
- sb 0x05 data 0x00000012 -> resp 3 cycles after accept, one dm_wr pulse with dm_wdata=0x889912BB; a following lw 0x04 -> 0x889912BB.
- lh 0x05, LSU_ALIGN_CHK_EN defined -> resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, dm_wr never high. Same request with the macro undefined -> returns 0xFFFFAABB-style data from lane addr[1]=0.
- sh 0x04 data 0x5555, rst_n pulsed low during RMW_RD -> dm_wr never asserted, all outputs at reset values, lw 0x04 afterwards returns the old word.
- req_valid held high across back-to-back lw 0x04 / lw 0x08 -> req_ready low from accept until after RESP. Second accepted in the IDLE cycle after the first resp_valid; two responses, in order.

Source files
------------

// File: rtl/lsu_dm_ctrl_if.sv
// Request/response and data-memory bus of the load/store controller.
// slave is the controller's view. master is the surrounding pipeline and
// memory: it drives the requests and memory read data, and it observes the
// responses and memory strobes.
interface lsu_dm_ctrl_if #(
  parameter int unsigned AW = 6
);
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          resp_valid;
  logic          resp_err;
  logic [DW-1:0] resp_rdata;

  logic [AW-1:0] dm_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dm_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  dm_addr, dm_rd, dm_wr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dm_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output dm_addr, dm_rd, dm_wr, dm_wdata
  );
endinterface

// File: rtl/lsu_dm_ctrl.sv
// Load/store controller between the EX/MEM pipeline register and a
// 64-word x 32-bit data memory. It turns byte, halfword and word requests
// into word accesses. Partial stores use read-modify-write, and loads are
// sign- or zero-extended.
// Optional feature: define LSU_ALIGN_CHK_EN to enable misalignment detection
// and error responses. Without this macro, accesses are forced aligned and
// resp_err stays 0.
module lsu_dm_ctrl #(
  parameter int unsigned AW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_dm_ctrl_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [HW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          resp_valid_q;
  logic          req_ready_q;
  logic          dm_wr_q;

  logic          misalign_c;
  logic [BW-1:0] byte_c;
  logic [HW-1:0] half_c;
  logic [DW-1:0] load_c;
  logic [DW-1:0] merged_c;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[DW-1:AW+2];

  // Detect a misaligned request in the incoming request fields.
`ifdef LSU_ALIGN_CHK_EN
  always_comb begin
    misalign_c = 1'b0;
    if (bus.req_size == 2'b01) begin
      misalign_c = bus.req_addr[0];
    end else if (bus.req_size[1]) begin
      misalign_c = |bus.req_addr[1:0];
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Extract the load lane from memory data and extend it to 32 bits.
  always_comb begin
    byte_c = bus.dm_rdata[{lane_q, 3'b000} +: BW];
    half_c = bus.dm_rdata[{lane_q[1], 4'b0000} +: HW];
    case (size_q)
      2'b00:   load_c = uns_q ? {24'd0, byte_c} : {{24{byte_c[BW-1]}}, byte_c};
      2'b01:   load_c = uns_q ? {16'd0, half_c} : {{16{half_c[HW-1]}}, half_c};
      default: load_c = bus.dm_rdata;
    endcase
  end

  // Merge the captured byte or halfword into the word that was read.
  always_comb begin
    merged_c = bus.dm_rdata;
    if (size_q == 2'b00) begin
      merged_c[{lane_q, 3'b000} +: BW] = wdata_q[BW-1:0];
    end else begin
      merged_c[{lane_q[1], 4'b0000} +: HW] = wdata_q;
    end
  end

  // Compute the next state and the next value of each captured register.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d    = bus.req_size;
          uns_d     = bus.req_unsigned;
          lane_d    = bus.req_addr[1:0];
          wdata_d   = bus.req_wdata[HW-1:0];
          dm_addr_d = bus.req_addr[AW+1:2];
          if (misalign_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!bus.req_we) begin
            state_d = LOAD;
          end else if (bus.req_size[1]) begin
            dm_wdata_d = bus.req_wdata;
            state_d    = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_c;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RMW_RD: begin
        dm_wdata_d = merged_c;
        state_d    = RMW_WR;
      end
      WR, RMW_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Update the state and the captured registers. The strobes are registered
  // from the next state, so the req_* inputs reach dm_* only through a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      dm_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= (state_d == RESP);
      req_ready_q  <= (state_d == IDLE);
      dm_wr_q      <= (state_d == WR) || (state_d == RMW_WR);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_wr      = dm_wr_q;
  assign bus.dm_rd      = dm_wr_q;
  assign bus.dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
// Testbench for lsu_dm_ctrl: directed vector table, multi-cycle corner cases
// (mid-operation reset, back-to-back requests) and randomized traffic
// against an arithmetic reference model.
module tb_lsu_dm_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned NW = 64;

  logic clk;
  logic rst_n;
  logic mem_clr;

  lsu_dm_ctrl_if #(.AW(AW)) bus ();

  lsu_dm_ctrl #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: combinational read, synchronous write.
  logic [31:0] mem [NW];
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(NW); i++) mem[i] <= '0;
    end else if (bus.dm_wr) begin
      mem[bus.dm_addr] <= bus.dm_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference memory content, kept as word values.
  logic [31:0] ref_mem [NW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: compute the expected response and update ref_mem from the access rules.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] e_rdata, output logic e_err,
                        output int e_lat, output int e_wr, output logic [31:0] e_word);
    int idx;
    int sz;
    int bad;
    logic [31:0] w, v, mask, sh;
    idx = int'((addr >> 2) % 64);
    sz  = (size == 2'd3) ? 2 : int'(size);
    bad = 0;
`ifdef LSU_ALIGN_CHK_EN
    if (sz == 1 && (addr % 2) != 0) bad = 1;
    if (sz == 2 && (addr % 4) != 0) bad = 1;
`endif
    w = ref_mem[idx];
    e_rdata = '0; e_err = 1'b0; e_wr = 0; e_word = w;
    if (bad != 0) begin
      e_err = 1'b1; e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      if (sz == 0) begin
        v = (w >> (8 * (addr % 4))) & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 1) begin
        v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end else begin
        v = w;
      end
      e_rdata = v;
    end else begin
      e_wr = 1;
      if (sz == 2) begin
        e_lat = 2;
        v = wdata;
      end else begin
        e_lat = 3;
        mask = (sz == 0) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
        v = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      end
      ref_mem[idx] = v;
      e_word = v;
    end
  endtask

  // Issue one request and observe it until its response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nwr, output logic [31:0] wseen, output int rdmis);
    int waitc;
    lat = 99; rdata = '0; err = 1'b0; nwr = 0; wseen = '0; rdmis = 0; waitc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.dm_wr) begin nwr++; wseen = bus.dm_wdata; end
      if (bus.dm_rd !== bus.dm_wr) rdmis++;
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat;
    vt.push_back(v);
  endtask

  initial begin
    int lat, nwr, rdmis, e_lat, e_wr;
    logic [31:0] rd, ws, e_rd, e_word;
    logic er, e_er;
    logic [31:0] w1, w2;
    int rp[5];
    int rv[5];
    logic [31:0] rdv[5];

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = '0;

    // Reset and reset-value checks.
    rst_n = 1'b0; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_dm_wr", 32'(bus.dm_wr), 32'd0);
    chk("rst_dm_rd", 32'(bus.dm_rd), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
    rst_n = 1'b1; mem_clr = 1'b0;

    // Directed vectors: {we, size, uns, addr, wdata, rdata, err, latency}.
    add(1, 2'b10, 0, 32'h04, 32'h8899AABB, 32'h0, 0, 2);
    add(0, 2'b10, 0, 32'h04, 32'h0, 32'h8899AABB, 0, 2);
    add(0, 2'b00, 0, 32'h07, 32'h0, 32'hFFFFFF88, 0, 2);
    add(0, 2'b00, 1, 32'h07, 32'h0, 32'h00000088, 0, 2);
    add(0, 2'b01, 0, 32'h04, 32'h0, 32'hFFFFAABB, 0, 2);
    add(0, 2'b01, 1, 32'h06, 32'h0, 32'h00008899, 0, 2);
`ifdef LSU_ALIGN_CHK_EN
    add(0, 2'b01, 0, 32'h05, 32'h0, 32'h0, 1, 1);
`else
    add(0, 2'b01, 0, 32'h05, 32'h0, 32'hFFFFAABB, 0, 2);
`endif
    add(1, 2'b00, 0, 32'h05, 32'h00000012, 32'h0, 0, 3);
    add(0, 2'b10, 0, 32'h04, 32'h0, 32'h889912BB, 0, 2);
    add(1, 2'b11, 0, 32'h100, 32'hCAFEF00D, 32'h0, 0, 2);
    add(0, 2'b10, 0, 32'h000, 32'h0, 32'hCAFEF00D, 0, 2);
    add(1, 2'b01, 0, 32'h0A, 32'hFFFF1234, 32'h0, 0, 3);
    add(0, 2'b01, 0, 32'h0A, 32'h0, 32'h00001234, 0, 2);
    add(0, 2'b00, 0, 32'h0B, 32'h0, 32'h00000012, 0, 2);
    add(0, 2'b00, 1, 32'h0A, 32'h0, 32'h00000034, 0, 2);
`ifdef LSU_ALIGN_CHK_EN
    add(0, 2'b10, 0, 32'h09, 32'h0, 32'h0, 1, 1);
    add(1, 2'b10, 0, 32'h06, 32'h11223344, 32'h0, 1, 1);
    add(0, 2'b10, 0, 32'h04, 32'h0, 32'h889912BB, 0, 2);
    add(1, 2'b01, 0, 32'h0F, 32'h0000ABCD, 32'h0, 1, 1);
    add(0, 2'b10, 0, 32'h0C, 32'h0, 32'h00000000, 0, 2);
`else
    add(0, 2'b10, 0, 32'h09, 32'h0, 32'h12340000, 0, 2);
    add(1, 2'b10, 0, 32'h06, 32'h11223344, 32'h0, 0, 2);
    add(0, 2'b10, 0, 32'h04, 32'h0, 32'h11223344, 0, 2);
    add(1, 2'b01, 0, 32'h0F, 32'h0000ABCD, 32'h0, 0, 3);
    add(0, 2'b10, 0, 32'h0C, 32'h0, 32'hABCD0000, 0, 2);
`endif

    foreach (vt[i]) begin
      ref_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, e_rd, e_er, e_lat, e_wr, e_word);
      do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, lat, rd, er, nwr, ws, rdmis);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_dm_wr_cycles", i), 32'(nwr), (vt[i].we && !vt[i].err) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_dm_rd_eq_wr", i), 32'(rdmis), 32'd0);
    end

    // Partial store abandoned by a reset during the read phase.
    @(negedge clk);
    chk("rmw_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h04; bus.req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_dm_wr", 32'(bus.dm_wr), 32'd0);
    chk("rmw_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rmw_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rmw_rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rmw_rst_dm_wdata", bus.dm_wdata, 32'd0);
    chk("rmw_rst_resp_rdata", bus.resp_rdata, 32'd0);
    nwr = 0; rdmis = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.dm_wr) nwr++;
      if (bus.resp_valid) rdmis++;
    end
    chk("rmw_rst_no_write", 32'(nwr), 32'd0);
    chk("rmw_rst_no_resp", 32'(rdmis), 32'd0);
    do_req(0, 2'b10, 0, 32'h04, 32'h0, lat, rd, er, nwr, ws, rdmis);
    chk("rmw_rst_old_word", rd, ref_mem[1]);

    // Word store abandoned by a reset while its write strobe is high.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h08; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("wr_strobe_high", 32'(bus.dm_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_async_drop", 32'(bus.dm_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 2'b10, 0, 32'h08, 32'h0, lat, rd, er, nwr, ws, rdmis);
    chk("wr_rst_old_word", rd, ref_mem[2]);

    // Back-to-back loads with req_valid held high.
    w1 = ref_mem[1]; w2 = ref_mem[2];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h04;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req_addr = 32'h08;
      if (c == 3) bus.req_valid = 1'b0;
      rp[c] = int'(bus.req_ready); rv[c] = int'(bus.resp_valid); rdv[c] = bus.resp_rdata;
    end
    chk("b2b_ready_c1", 32'(rp[0]), 32'd0);
    chk("b2b_ready_c2", 32'(rp[1]), 32'd0);
    chk("b2b_ready_c3", 32'(rp[2]), 32'd1);
    chk("b2b_ready_c4", 32'(rp[3]), 32'd0);
    chk("b2b_ready_c5", 32'(rp[4]), 32'd0);
    chk("b2b_resp_c2", 32'(rv[1]), 32'd1);
    chk("b2b_resp_c3", 32'(rv[2]), 32'd0);
    chk("b2b_resp_c5", 32'(rv[4]), 32'd1);
    chk("b2b_data_first", rdv[1], w1);
    chk("b2b_data_hold", rdv[2], w1);
    chk("b2b_data_second", rdv[4], w2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic        r_we;
      logic [1:0]  r_sz;
      logic        r_un;
      logic [31:0] r_ad, r_wd;
      r_we = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_un = 1'($urandom_range(0, 1));
      r_ad = (n % 2 == 0) ? 32'($urandom_range(0, 511)) : $urandom;
      r_wd = $urandom;
      ref_op(r_we, r_sz, r_un, r_ad, r_wd, e_rd, e_er, e_lat, e_wr, e_word);
      do_req(r_we, r_sz, r_un, r_ad, r_wd, lat, rd, er, nwr, ws, rdmis);
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_dm_wr_cycles", n), 32'(nwr), 32'(e_wr));
      chk($sformatf("rnd%0d_dm_rd_eq_wr", n), 32'(rdmis), 32'd0);
      if (e_wr != 0) chk($sformatf("rnd%0d_dm_wdata", n), ws, e_word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
